// File: rtl/bf16_mul_sched.sv
// Purpose: arbitrates two bfloat16 requesters onto one shared multiplier and returns each result to its owner.
// Latency: accept at edge E0 -> mul_go in C1 -> mul_res sampled end of C(1+LAT) -> rsp valid from C(2+LAT).
// Backpressure: a requester stays busy (not grantable) until its held response is consumed via rspi_ready.
// Optional feature: define BF16_SCHED_STATS_EN to add saturating per-requester accept counters cnt0/cnt1.
module bf16_mul_sched #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_go,
  input  logic [15:0] mul_res,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp0_data,
  output logic [15:0] rsp1_data,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready
`ifdef BF16_SCHED_STATS_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);

  logic           busy0, busy1;
  logic           last_id;      // requester served most recently
  logic           go_id;        // requester owning the op on mul_a/mul_b
  logic           elig0, elig1;
  logic           gnt0, gnt1;
  logic           acc0, acc1;
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_id;
  logic           cap0, cap1;

  // Round-robin grant from registered busy flags; gated by rst_n so ready is low during reset.
  always_comb begin
    elig0 = req0_valid & ~busy0;
    elig1 = req1_valid & ~busy1;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (elig0 && elig1) begin
      if (last_id) gnt0 = 1'b1;
      else         gnt1 = 1'b1;
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
    gnt0 = gnt0 & rst_n;
    gnt1 = gnt1 & rst_n;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc0       = req0_valid & gnt0;
  assign acc1       = req1_valid & gnt1;

  // Result capture when the tag pipeline's last stage says that requester's op is on mul_res.
  assign cap0 = tag_v[LAT-1] & ~tag_id[LAT-1];
  assign cap1 = tag_v[LAT-1] &  tag_id[LAT-1];

  // Issue stage: register operands and a one-cycle go strobe on accept; operands hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a   <= 16'h0000;
      mul_b   <= 16'h0000;
      mul_go  <= 1'b0;
      go_id   <= 1'b0;
      last_id <= 1'b1;
    end else begin
      mul_go <= acc0 | acc1;
      if (acc0) begin
        mul_a   <= req0_a;
        mul_b   <= req0_b;
        go_id   <= 1'b0;
        last_id <= 1'b0;
      end else if (acc1) begin
        mul_a   <= req1_a;
        mul_b   <= req1_b;
        go_id   <= 1'b1;
        last_id <= 1'b1;
      end
    end
  end

  // Tag shift pipeline: stage k is valid in cycle C(2+k), so stage LAT-1 aligns with mul_res.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= mul_go;
      tag_id[0] <= go_id;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Busy flags: set on accept, cleared when the held response is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy0 <= 1'b0;
      busy1 <= 1'b0;
    end else begin
      if (acc0)                          busy0 <= 1'b1;
      else if (rsp0_valid && rsp0_ready) busy0 <= 1'b0;
      if (acc1)                          busy1 <= 1'b1;
      else if (rsp1_valid && rsp1_ready) busy1 <= 1'b0;
    end
  end

  // Response holding registers; busy guarantees capture and consume never coincide per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= 16'h0000;
      rsp1_data  <= 16'h0000;
    end else begin
      if (cap0) begin
        rsp0_valid <= 1'b1;
        rsp0_data  <= mul_res;
      end else if (rsp0_valid && rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (cap1) begin
        rsp1_valid <= 1'b1;
        rsp1_data  <= mul_res;
      end else if (rsp1_valid && rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

`ifdef BF16_SCHED_STATS_EN
  // Saturating accept counters per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 16'h0000;
      cnt1 <= 16'h0000;
    end else begin
      if (acc0 && (cnt0 != 16'hFFFF)) cnt0 <= cnt0 + 16'h0001;
      if (acc1 && (cnt1 != 16'hFFFF)) cnt1 <= cnt1 + 16'h0001;
    end
  end
`endif

endmodule
